// File: rtl/data_ram_be.sv
// Byte-addressed data memory for the MIPS datapath: byte/half/word loads and stores,
// alignment/range error reporting, post-reset clear and a registered one-cycle response.
module data_ram_be #(
  parameter int ADDR_W         = 13,
  parameter int DEPTH          = 2048,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t            state;
  logic [IDX_W-1:0]  cnt;
  logic [31:0]       mem [DEPTH];

  logic [ADDR_W-3:0] widx;
  logic [IDX_W-1:0]  midx;
  logic [1:0]        lane;
  logic              accept;
  logic              err;
  logic              do_store;
  logic [3:0]        be;
  logic [31:0]       wlanes;
  logic [31:0]       rd_word;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_data;

  assign widx      = req_addr[ADDR_W-1:2];
  assign midx      = widx[IDX_W-1:0];
  assign lane      = req_addr[1:0];
  assign req_ready = (state == S_READY);
  assign busy      = (state == S_INIT);
  assign accept    = req_valid & req_ready;
  assign do_store  = rst_n & accept & req_we & ~err;

  // Error priority: illegal size, half misalignment, word misalignment, then range.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    err = 1'b0;
    if (req_size == 2'd3)                         err = 1'b1;
    else if (req_size == 2'd1 && req_addr[0])     err = 1'b1;
    else if (req_size == 2'd2 && lane != 2'b00)   err = 1'b1;
    else if ({1'b0, widx} >= (ADDR_W-1)'(DEPTH))  err = 1'b1;
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    be     = 4'b0000;
    wlanes = req_wdata;
    case (req_size)
      2'd0: begin
        be          = 4'b0000;
        be[lane]    = 1'b1;
        wlanes      = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        be     = req_addr[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{req_wdata[15:0]}};
      end
      2'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // NOTE: the memory array has no reset branch; clearing is done by the INIT sequence,
  // which keeps the array mappable onto block RAM.
  always_ff @(posedge clk) begin
    if (rst_n && state == S_INIT) begin
      mem[cnt] <= '0;
    end else if (do_store) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[midx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  assign rd_word  = mem[midx];
  assign byte_sel = rd_word[{lane, 3'b000} +: 8];
  assign half_sel = req_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_data = rd_word;
    case (req_size)
      2'd0:    load_data = req_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'd1:    load_data = req_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_data = rd_word;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= (CLEAR_ON_RESET != 0) ? S_INIT : S_READY;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= accept;
      if (accept) begin
        rsp_err   <= err;
        rsp_rdata <= (err || req_we) ? 32'h0 : load_data;
      end
      if (state == S_INIT) begin
        cnt <= cnt + 1'b1;
        if (cnt == IDX_W'(DEPTH - 1)) state <= S_READY;
      end
    end
  end

endmodule

// File: tb/tb_data_ram_be.sv
// Directed bench for data_ram_be: clear timing, byte/half/word access, extension,
// error reporting, back-to-back traffic and reset during INIT and response.
module tb_data_ram_be;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [12:0] req_addr;
  logic [31:0] req_wdata;

  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic        s_req_ready, s_rsp_valid, s_rsp_err, s_busy;
  logic [31:0] s_rsp_rdata;

  int n_cmp  = 0;
  int n_fail = 0;
  int cycles;

  always #5 clk = ~clk;

  data_ram_be #(.ADDR_W(13), .DEPTH(2048), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  data_ram_be #(.ADDR_W(13), .DEPTH(1024), .CLEAR_ON_RESET(0)) dut_small (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(s_req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(s_rsp_valid),
    .rsp_rdata(s_rsp_rdata), .rsp_err(s_rsp_err), .busy(s_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for one edge, then drop req_valid; response is visible on return.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [12:0] addr, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_init(input string tag);
    cycles = 0;
    while (busy === 1'b1 && cycles < 5000) begin
      check({tag, "_ready_low"}, {31'h0, req_ready}, 32'h0);
      tick();
      cycles++;
    end
    check({tag, "_cycles"}, cycles, 32'd2048);
    check({tag, "_busy_done"}, {31'h0, busy}, 32'h0);
    check({tag, "_ready_done"}, {31'h0, req_ready}, 32'h1);
  endtask

  task automatic load_chk(input string tag, input logic [1:0] size, input logic uns,
                          input logic [12:0] addr, input logic [31:0] exp);
    do_req(1'b0, size, uns, addr, 32'h0);
    check({tag, "_valid"}, {31'h0, rsp_valid}, 32'h1);
    check({tag, "_err"}, {31'h0, rsp_err}, 32'h0);
    check({tag, "_data"}, rsp_rdata, exp);
  endtask

  task automatic store_chk(input string tag, input logic [1:0] size,
                           input logic [12:0] addr, input logic [31:0] wdata, input logic exp_err);
    do_req(1'b1, size, 1'b0, addr, wdata);
    check({tag, "_valid"}, {31'h0, rsp_valid}, 32'h1);
    check({tag, "_err"}, {31'h0, rsp_err}, {31'h0, exp_err});
    check({tag, "_data"}, rsp_rdata, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    tick();
    tick();
    check("rst_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_err", {31'h0, rsp_err}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h1);
    check("small_ready", {31'h0, s_req_ready}, 32'h0 | {31'h0, 1'b1});
    rst_n = 1'b1;
    wait_init("init1");

    load_chk("lw_top", 2'd2, 1'b0, 13'h1FFC, 32'h0000_0000);

    store_chk("sw_10", 2'd2, 13'h0010, 32'h1122_3344, 1'b0);
    load_chk("lb_11", 2'd0, 1'b0, 13'h0011, 32'h0000_0033);
    store_chk("sb_12", 2'd0, 13'h0012, 32'h0000_00AA, 1'b0);
    load_chk("lw_10", 2'd2, 1'b0, 13'h0010, 32'h11AA_3344);
    load_chk("lh_12", 2'd1, 1'b0, 13'h0012, 32'h0000_11AA);

    store_chk("sw_20", 2'd2, 13'h0020, 32'h80F0_FF7F, 1'b0);
    load_chk("lb_21", 2'd0, 1'b0, 13'h0021, 32'hFFFF_FFFF);
    load_chk("lbu_21", 2'd0, 1'b1, 13'h0021, 32'h0000_00FF);
    load_chk("lh_22", 2'd1, 1'b0, 13'h0022, 32'hFFFF_80F0);
    load_chk("lhu_22", 2'd1, 1'b1, 13'h0022, 32'h0000_80F0);
    load_chk("lbu_20", 2'd0, 1'b1, 13'h0020, 32'h0000_007F);

    store_chk("sw_mis", 2'd2, 13'h0006, 32'h1234_5678, 1'b1);
    load_chk("lw_04", 2'd2, 1'b0, 13'h0004, 32'h0000_0000);
    store_chk("sh_mis", 2'd1, 13'h0003, 32'hBEEF_CAFE, 1'b1);
    load_chk("lw_00", 2'd2, 1'b0, 13'h0000, 32'h0000_0000);
    store_chk("size3", 2'd3, 13'h0010, 32'h5555_5555, 1'b1);
    load_chk("lw_10u", 2'd2, 1'b0, 13'h0010, 32'h11AA_3344);

    do_req(1'b0, 2'd2, 1'b0, 13'h1000, 32'h0);
    check("small_range_valid", {31'h0, s_rsp_valid}, 32'h1);
    check("small_range_err", {31'h0, s_rsp_err}, 32'h1);
    check("small_range_data", s_rsp_rdata, 32'h0);
    check("big_1000_err", {31'h0, rsp_err}, 32'h0);

    // Back-to-back store then load of the same word.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 13'h0040; req_wdata = 32'hDEAD_BEEF;
    tick();
    check("b2b_st_valid", {31'h0, rsp_valid}, 32'h1);
    check("b2b_st_data", rsp_rdata, 32'h0);
    req_we = 1'b0; req_wdata = 32'h0;
    tick();
    req_valid = 1'b0;
    check("b2b_ld_valid", {31'h0, rsp_valid}, 32'h1);
    check("b2b_ld_data", rsp_rdata, 32'hDEAD_BEEF);
    tick();
    check("idle_valid", {31'h0, rsp_valid}, 32'h0);
    check("idle_hold", rsp_rdata, 32'hDEAD_BEEF);

    // Reset the cycle after a load is accepted.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 13'h0010;
    tick();
    req_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    check("rstld_valid", {31'h0, rsp_valid}, 32'h0);
    check("rstld_rdata", rsp_rdata, 32'h0);
    check("rstld_busy", {31'h0, busy}, 32'h1);
    rst_n = 1'b1;

    // Reset after 500 INIT cycles restarts the full clear.
    for (int i = 0; i < 500; i++) tick();
    check("mid_init_busy", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_init("init2");
    load_chk("lw_10_clr", 2'd2, 1'b0, 13'h0010, 32'h0000_0000);
    load_chk("lw_40_clr", 2'd2, 1'b0, 13'h0040, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
